// File: rtl/sensor_packet_parser.sv
// ----------------------------------------------------------------------------
// sensor_packet_parser
//
// Purpose:
//   Parses sensor packets arriving on an AXI4-Stream slave. Each packet is
//     0xAAAAAAAA header, 0x00000000 dummy, timestamp, payload, 0x55555555 footer.
//   The payload is one of two kinds:
//     - raw mode: 512 words, each holding two 12-bit pixels. The pixels are
//       unpacked onto a pixel stream with a one-cycle valid qualifier.
//     - processed mode: 3 words that form a 48-bit C sum and a 48-bit D sum.
//       The sums are published when a good footer arrives.
//   In IDLE, the word 0xBBBBBBBB with s_tlast=1 marks the end of a frame.
//
// Ports:
//   master_clock       40 MHz clock. All logic runs on its rising edge.
//   resetn             Synchronous, active-low reset.
//   raw_mode           Payload type: 1 = raw pixels, 0 = processed sums.
//                      It is sampled when a header is accepted.
//   s_tdata/s_tvalid/s_tlast/s_tready
//                      AXI4-Stream slave input.
//   pix_data/pix_index/pix_valid
//                      Unpacked raw pixel stream. There is no backpressure.
//   time_stamp         Timestamp of the last accepted packet.
//   c_sum/d_sum/sum_valid
//                      Processed sums. sum_valid is a one-cycle pulse.
//   pkt_done           Pulse: a packet ended with a good footer.
//   frame_done         Pulse: a frame-end marker was received.
//   err_pulse          Pulse: a protocol error was detected.
//   dbg_state          Registered FSM state.
//                      IDLE=0, DUMMY=1, TSTAMP=2, RAW=3, PROC=4, FOOTER=5.
//   err_count          Saturating 16-bit error counter. This port exists only
//                      when SENSOR_PARSER_ERR_CNT_EN is defined.
//
// Build option:
//   SENSOR_PARSER_ERR_CNT_EN  Adds the err_count output and its counter.
// ----------------------------------------------------------------------------
module sensor_packet_parser (
  input  logic        master_clock,
  input  logic        resetn,
  input  logic        raw_mode,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [11:0] pix_data,
  output logic [9:0]  pix_index,
  output logic        pix_valid,
  output logic [31:0] time_stamp,
  output logic [47:0] c_sum,
  output logic [47:0] d_sum,
  output logic        sum_valid,
  output logic        pkt_done,
  output logic        frame_done,
  output logic        err_pulse,
  output logic [3:0]  dbg_state
`ifdef SENSOR_PARSER_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam logic [31:0] HEADER_WORD    = 32'hAAAA_AAAA;
  localparam logic [31:0] DUMMY_WORD     = 32'h0000_0000;
  localparam logic [31:0] FRAME_END_WORD = 32'hBBBB_BBBB;
  localparam logic [31:0] FOOTER_WORD    = 32'h5555_5555;
  localparam logic [8:0]  LAST_RAW_WORD  = 9'd511;
  localparam logic [1:0]  LAST_PROC_WORD = 2'd2;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    DUMMY  = 4'd1,
    TSTAMP = 4'd2,
    RAW    = 4'd3,
    PROC   = 4'd4,
    FOOTER = 4'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic        beat;
  logic        hdr_accept;
  logic        ts_load;
  logic        raw_beat;
  logic        proc_beat;
  logic        err_next;
  logic        pkt_next;
  logic        frame_next;
  logic        sum_next;

  logic        raw_latched;
  logic [8:0]  raw_count;
  logic [1:0]  proc_count;
  logic [31:0] w0;
  logic [31:0] w1;
  logic [47:0] c_pend;
  logic [47:0] d_pend;
  logic [11:0] odd_data;
  logic        odd_pending;

  logic        pix_valid_q;
  logic        sum_valid_q;
  logic        pkt_done_q;
  logic        frame_done_q;
  logic        err_pulse_q;

  // A raw word is split over two cycles: the even pixel goes out first, then
  // the odd pixel. s_tready drops for one cycle in RAW while the odd pixel is
  // moved into the output register. This stops a new even pixel from
  // colliding with it. The 512th word moves the FSM to FOOTER with its odd
  // pixel still pending. That pixel is still emitted, and FOOTER keeps
  // s_tready high.
  assign s_tready = resetn && !((state == RAW) && odd_pending);
  assign beat     = s_tvalid && s_tready;

  // The pulse outputs are gated with resetn. This keeps them low for the
  // whole time reset is asserted, including the cycle before the first
  // reset edge.
  assign pix_valid  = pix_valid_q  && resetn;
  assign sum_valid  = sum_valid_q  && resetn;
  assign pkt_done   = pkt_done_q   && resetn;
  assign frame_done = frame_done_q && resetn;
  assign err_pulse  = err_pulse_q  && resetn;
  assign dbg_state  = state;

  always_ff @(posedge master_clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and one-cycle event strobes.
  // s_tlast inside a packet is treated as a framing error and takes priority
  // over the per-state handling.
  always_comb begin
    next_state = state;
    hdr_accept = 1'b0;
    ts_load    = 1'b0;
    raw_beat   = 1'b0;
    proc_beat  = 1'b0;
    err_next   = 1'b0;
    pkt_next   = 1'b0;
    frame_next = 1'b0;
    sum_next   = 1'b0;

    if (beat) begin
      if ((state != IDLE) && s_tlast) begin
        err_next   = 1'b1;
        next_state = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (s_tdata == HEADER_WORD) begin
              hdr_accept = 1'b1;
              next_state = DUMMY;
            end else if ((s_tdata == FRAME_END_WORD) && s_tlast) begin
              frame_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
          DUMMY: begin
            if (s_tdata == DUMMY_WORD) begin
              next_state = TSTAMP;
            end else begin
              err_next   = 1'b1;
              next_state = IDLE;
            end
          end
          TSTAMP: begin
            ts_load    = 1'b1;
            next_state = raw_latched ? RAW : PROC;
          end
          RAW: begin
            raw_beat = 1'b1;
            if (raw_count == LAST_RAW_WORD) begin
              next_state = FOOTER;
            end
          end
          PROC: begin
            proc_beat = 1'b1;
            if (proc_count == LAST_PROC_WORD) begin
              next_state = FOOTER;
            end
          end
          FOOTER: begin
            if (s_tdata == FOOTER_WORD) begin
              pkt_next = 1'b1;
              sum_next = !raw_latched;
            end else begin
              err_next = 1'b1;
            end
            next_state = IDLE;
          end
          default: begin
            next_state = IDLE;
          end
        endcase
      end
    end
  end

  // Datapath registers.
  // The sums are built into c_pend/d_pend as the payload arrives. They are
  // copied to c_sum/d_sum only on a good footer, so a bad packet leaves the
  // published sums untouched.
  always_ff @(posedge master_clock) begin
    if (!resetn) begin
      raw_latched  <= 1'b0;
      raw_count    <= '0;
      proc_count   <= '0;
      w0           <= '0;
      w1           <= '0;
      c_pend       <= '0;
      d_pend       <= '0;
      odd_data     <= '0;
      odd_pending  <= 1'b0;
      time_stamp   <= '0;
      c_sum        <= '0;
      d_sum        <= '0;
      pix_data     <= '0;
      pix_index    <= '0;
      pix_valid_q  <= 1'b0;
      sum_valid_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_pulse_q  <= 1'b0;
    end else begin
      pix_valid_q  <= 1'b0;
      sum_valid_q  <= sum_next;
      pkt_done_q   <= pkt_next;
      frame_done_q <= frame_next;
      err_pulse_q  <= err_next;

      if (hdr_accept) begin
        raw_latched <= raw_mode;
      end

      if (ts_load) begin
        time_stamp <= s_tdata;
        raw_count  <= '0;
        proc_count <= '0;
      end

      if (raw_beat) begin
        pix_data    <= s_tdata[27:16];
        pix_index   <= {raw_count, 1'b0};
        pix_valid_q <= 1'b1;
        odd_data    <= s_tdata[11:0];
        odd_pending <= 1'b1;
        raw_count   <= raw_count + 9'd1;
      end else if (odd_pending) begin
        pix_data    <= odd_data;
        pix_index   <= {pix_index[9:1], 1'b1};
        pix_valid_q <= 1'b1;
        odd_pending <= 1'b0;
      end

      if (proc_beat) begin
        case (proc_count)
          2'd0:    w0 <= s_tdata;
          2'd1:    w1 <= s_tdata;
          default: begin
            c_pend <= {w1[15:0], w0};
            d_pend <= {s_tdata, w1[31:16]};
          end
        endcase
        proc_count <= proc_count + 2'd1;
      end

      if (sum_next) begin
        c_sum <= c_pend;
        d_sum <= d_pend;
      end
    end
  end

`ifdef SENSOR_PARSER_ERR_CNT_EN
  // The counter saturates so that a long error storm cannot wrap it back to
  // a small, misleading value.
  always_ff @(posedge master_clock) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (err_next && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sensor_packet_parser.sv
// ----------------------------------------------------------------------------
// tb_sensor_packet_parser
//
// Purpose:
//   Directed self-checking bench for sensor_packet_parser. It covers:
//     - raw packets, with and without s_tvalid gaps;
//     - processed packets and the frame-end marker;
//     - malformed packets;
//     - reset in the middle of a packet.
//   Expected pixels are pushed into a queue by the stimulus code and popped by
//   a pixel monitor. Event pulses are counted by the same monitor.
// ----------------------------------------------------------------------------
module tb_sensor_packet_parser;

  localparam logic [31:0] HEADER_WORD    = 32'hAAAA_AAAA;
  localparam logic [31:0] FRAME_END_WORD = 32'hBBBB_BBBB;
  localparam logic [31:0] FOOTER_WORD    = 32'h5555_5555;

  logic        master_clock = 1'b0;
  logic        resetn       = 1'b0;
  logic        raw_mode     = 1'b0;
  logic [31:0] s_tdata      = '0;
  logic        s_tvalid     = 1'b0;
  logic        s_tlast      = 1'b0;
  logic        s_tready;
  logic [11:0] pix_data;
  logic [9:0]  pix_index;
  logic        pix_valid;
  logic [31:0] time_stamp;
  logic [47:0] c_sum;
  logic [47:0] d_sum;
  logic        sum_valid;
  logic        pkt_done;
  logic        frame_done;
  logic        err_pulse;
  logic [3:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int err_seen   = 0;
  int pkt_seen   = 0;
  int frame_seen = 0;
  int sum_seen   = 0;
  int pix_seen   = 0;

  // Each entry is {pixel index, pixel data}.
  logic [21:0] exp_q[$];

  sensor_packet_parser dut (
    .master_clock (master_clock),
    .resetn       (resetn),
    .raw_mode     (raw_mode),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .pix_data     (pix_data),
    .pix_index    (pix_index),
    .pix_valid    (pix_valid),
    .time_stamp   (time_stamp),
    .c_sum        (c_sum),
    .d_sum        (d_sum),
    .sum_valid    (sum_valid),
    .pkt_done     (pkt_done),
    .frame_done   (frame_done),
    .err_pulse    (err_pulse),
    .dbg_state    (dbg_state)
  );

  always #5 master_clock = ~master_clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor: counts event pulses and checks every emitted pixel.
  always @(negedge master_clock) begin
    logic [21:0] exp;
    if (err_pulse)  err_seen++;
    if (pkt_done)   pkt_seen++;
    if (frame_done) frame_seen++;
    if (sum_valid) begin
      sum_seen++;
      checkOutput("sum_with_pkt", 64'(pkt_done), 64'd1);
    end
    if (pix_valid) begin
      pix_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("pix_unexpected", 64'(pix_index), 64'hFFFF);
      end else begin
        exp = exp_q.pop_front();
        checkOutput("pix_index", 64'(pix_index), 64'(exp[21:12]));
        checkOutput("pix_data", 64'(pix_data), 64'(exp[11:0]));
      end
    end
  end

  // Drives one word and waits, for a bounded time, until it is accepted.
  // odd_check: -1 means no check. Otherwise it is the s_tready value
  // required on the cycle after the beat.
  task automatic applyStimulus(input logic [31:0] data, input logic last,
                               input int gap, input int odd_check);
    int waits;
    @(negedge master_clock);
    repeat (gap) begin
      s_tvalid = 1'b0;
      @(negedge master_clock);
    end
    s_tdata  = data;
    s_tlast  = last;
    s_tvalid = 1'b1;
    waits    = 0;
    while (!s_tready && waits < 20) begin
      @(negedge master_clock);
      waits++;
    end
    if (!s_tready) begin
      checkOutput("tready_timeout", 64'(s_tready), 64'd1);
      s_tvalid = 1'b0;
      return;
    end
    @(posedge master_clock);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (odd_check >= 0) begin
      @(negedge master_clock);
      checkOutput("tready_odd", 64'(s_tready), 64'(odd_check));
    end
  endtask

  task automatic clear_counts();
    err_seen   = 0;
    pkt_seen   = 0;
    frame_seen = 0;
    sum_seen   = 0;
    pix_seen   = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge master_clock);
  endtask

  task automatic send_raw_prefix(input logic [31:0] ts, input bit gaps);
    raw_mode = 1'b1;
    applyStimulus(HEADER_WORD, 1'b0, gaps ? int'($urandom_range(0, 3)) : 0, -1);
    applyStimulus(32'h0, 1'b0, gaps ? int'($urandom_range(0, 3)) : 0, -1);
    applyStimulus(ts, 1'b0, gaps ? int'($urandom_range(0, 3)) : 0, -1);
    checkOutput("state_raw", 64'(dbg_state), 64'd3);
  endtask

  // dirty=1 sets the unused nibbles, to show that only the pixel fields are
  // taken.
  task automatic send_raw_words(input int count, input bit gaps, input bit dirty);
    logic [11:0] even_px;
    logic [11:0] odd_px;
    logic [31:0] word;
    for (int k = 0; k < count; k++) begin
      even_px = 12'(2 * k);
      odd_px  = 12'(2 * k + 1);
      word    = {dirty ? 4'hF : 4'h0, even_px, dirty ? 4'hA : 4'h0, odd_px};
      exp_q.push_back({10'(2 * k), even_px});
      exp_q.push_back({10'(2 * k + 1), odd_px});
      applyStimulus(word, 1'b0, gaps ? int'($urandom_range(0, 3)) : 0,
                    (k == 511) ? 1 : 0);
    end
  endtask

  task automatic send_raw_packet(input logic [31:0] ts, input bit gaps, input bit dirty);
    send_raw_prefix(ts, gaps);
    send_raw_words(512, gaps, dirty);
    applyStimulus(FOOTER_WORD, 1'b0, gaps ? int'($urandom_range(0, 3)) : 0, -1);
    wait_cycles(4);
  endtask

  task automatic send_proc_packet(input logic [31:0] ts, input logic [31:0] w0,
                                  input logic [31:0] w1, input logic [31:0] w2,
                                  input logic [31:0] footer);
    raw_mode = 1'b0;
    applyStimulus(HEADER_WORD, 1'b0, 0, -1);
    applyStimulus(32'h0, 1'b0, 0, -1);
    applyStimulus(ts, 1'b0, 0, -1);
    applyStimulus(w0, 1'b0, 0, -1);
    applyStimulus(w1, 1'b0, 0, -1);
    applyStimulus(w2, 1'b0, 0, -1);
    applyStimulus(footer, 1'b0, 0, -1);
    wait_cycles(4);
  endtask

  task automatic check_raw_result(input logic [31:0] ts);
    checkOutput("raw_pix_count", 64'(pix_seen), 64'd1024);
    checkOutput("raw_queue_left", 64'(exp_q.size()), 64'd0);
    checkOutput("raw_time_stamp", 64'(time_stamp), 64'(ts));
    checkOutput("raw_pkt_done", 64'(pkt_seen), 64'd1);
    checkOutput("raw_err", 64'(err_seen), 64'd0);
    checkOutput("raw_sum_valid", 64'(sum_seen), 64'd0);
    checkOutput("raw_state_idle", 64'(dbg_state), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    resetn = 1'b0;
    wait_cycles(3);
    checkOutput("rst_tready", 64'(s_tready), 64'd0);
    checkOutput("rst_pix_valid", 64'(pix_valid), 64'd0);
    checkOutput("rst_pulses", 64'({sum_valid, pkt_done, frame_done, err_pulse}), 64'd0);
    checkOutput("rst_time_stamp", 64'(time_stamp), 64'd0);
    checkOutput("rst_c_sum", 64'(c_sum), 64'd0);
    checkOutput("rst_d_sum", 64'(d_sum), 64'd0);
    checkOutput("rst_pix", 64'({pix_index, pix_data}), 64'd0);
    checkOutput("rst_state", 64'(dbg_state), 64'd0);
    resetn = 1'b1;
    #1;
    checkOutput("idle_tready", 64'(s_tready), 64'd1);

    // Raw packet with contiguous valid
    clear_counts();
    send_raw_packet(32'h1234_5678, 1'b0, 1'b0);
    check_raw_result(32'h1234_5678);

    // Processed packet
    clear_counts();
    send_proc_packet(32'hCAFE_F00D, 32'h0000_0010, 32'h0003_0000, 32'h0000_0005, FOOTER_WORD);
    checkOutput("proc_c_sum", 64'(c_sum), 64'h0000_0000_0010);
    checkOutput("proc_d_sum", 64'(d_sum), 64'h0000_0005_0003);
    checkOutput("proc_sum_valid", 64'(sum_seen), 64'd1);
    checkOutput("proc_pkt_done", 64'(pkt_seen), 64'd1);
    checkOutput("proc_err", 64'(err_seen), 64'd0);
    checkOutput("proc_time_stamp", 64'(time_stamp), 64'hCAFE_F00D);
    checkOutput("proc_no_pix", 64'(pix_seen), 64'd0);

    // Frame end, then the frame-end word without s_tlast
    clear_counts();
    applyStimulus(FRAME_END_WORD, 1'b1, 0, -1);
    wait_cycles(3);
    checkOutput("frame_done", 64'(frame_seen), 64'd1);
    checkOutput("frame_err", 64'(err_seen), 64'd0);
    clear_counts();
    applyStimulus(FRAME_END_WORD, 1'b0, 0, -1);
    wait_cycles(3);
    checkOutput("bbbb_nolast_err", 64'(err_seen), 64'd1);
    checkOutput("bbbb_nolast_frame", 64'(frame_seen), 64'd0);

    // Bad footer leaves the sums alone; the next packet still parses
    clear_counts();
    send_proc_packet(32'h0000_0001, 32'h1, 32'h2, 32'h3, 32'h5555_5554);
    checkOutput("badftr_err", 64'(err_seen), 64'd1);
    checkOutput("badftr_pkt", 64'(pkt_seen), 64'd0);
    checkOutput("badftr_sum_valid", 64'(sum_seen), 64'd0);
    checkOutput("badftr_c_sum", 64'(c_sum), 64'h0000_0000_0010);
    checkOutput("badftr_d_sum", 64'(d_sum), 64'h0000_0005_0003);
    clear_counts();
    send_proc_packet(32'h0000_0002, 32'h89AB_CDEF, 32'h1111_2222, 32'h3333_4444, FOOTER_WORD);
    checkOutput("after_c_sum", 64'(c_sum), 64'h2222_89AB_CDEF);
    checkOutput("after_d_sum", 64'(d_sum), 64'h3333_4444_1111);
    checkOutput("after_pkt", 64'(pkt_seen), 64'd1);
    checkOutput("after_err", 64'(err_seen), 64'd0);

    // Protocol errors in IDLE and DUMMY, and s_tlast mid-packet
    clear_counts();
    applyStimulus(32'h1234_5678, 1'b0, 0, -1);
    wait_cycles(2);
    checkOutput("idle_garbage_err", 64'(err_seen), 64'd1);
    clear_counts();
    applyStimulus(HEADER_WORD, 1'b0, 0, -1);
    applyStimulus(32'h0000_0001, 1'b0, 0, -1);
    wait_cycles(2);
    checkOutput("dummy_bad_err", 64'(err_seen), 64'd1);
    checkOutput("dummy_bad_state", 64'(dbg_state), 64'd0);
    clear_counts();
    applyStimulus(HEADER_WORD, 1'b0, 0, -1);
    applyStimulus(32'h0, 1'b1, 0, -1);
    wait_cycles(2);
    checkOutput("tlast_mid_err", 64'(err_seen), 64'd1);
    checkOutput("tlast_mid_state", 64'(dbg_state), 64'd0);

    // Raw packet with random s_tvalid gaps and dirty spare nibbles
    clear_counts();
    send_raw_packet(32'h0BAD_BEEF, 1'b1, 1'b1);
    check_raw_result(32'h0BAD_BEEF);

    // Reset in the middle of a raw packet, then a full packet
    clear_counts();
    send_raw_prefix(32'h0000_00AB, 1'b0);
    send_raw_words(100, 1'b0, 1'b0);
    wait_cycles(3);
    checkOutput("abort_pix_count", 64'(pix_seen), 64'd200);
    resetn = 1'b0;
    wait_cycles(2);
    checkOutput("abort_rst_tready", 64'(s_tready), 64'd0);
    checkOutput("abort_rst_ts", 64'(time_stamp), 64'd0);
    checkOutput("abort_rst_state", 64'(dbg_state), 64'd0);
    resetn = 1'b1;
    wait_cycles(2);
    checkOutput("abort_err", 64'(err_seen), 64'd0);
    exp_q.delete();
    clear_counts();
    send_raw_packet(32'h5A5A_0001, 1'b0, 1'b0);
    check_raw_result(32'h5A5A_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
